// File: rtl/prog_tick_divider_if.sv
// Control/status bundle for the programmable tick divider.
// The master side drives the controls; the slave side (the divider) reports status.
interface prog_tick_divider_if #(
  parameter int WIDTH = 16
);
  logic             enable;
  logic             clear;
  logic             start;
  logic             mode;
  logic             load;
  logic [WIDTH-1:0] max_in;
  logic             tick;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] max_cur;

  modport master (
    output enable, clear, start, mode, load, max_in,
    input  tick, busy, done, count, max_cur
  );

  modport slave (
    input  enable, clear, start, mode, load, max_in,
    output tick, busy, done, count, max_cur
  );
endinterface

// File: rtl/prog_tick_divider.sv
// Programmable tick divider: counts 0..max_cur and pulses tick on each wrap.
// Periodic or one-shot runs; terminal value updates while running are
// staged in a shadow register and only committed at a wrap, clear or reset.
module prog_tick_divider #(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] RST_MAX = 16'd9
) (
  input logic                 clk,
  input logic                 nRst,
  prog_tick_divider_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_reg;
  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] max_cur_reg;
  logic [WIDTH-1:0] shadow_reg;
  logic             pending_reg;
  logic             mode_q;
  logic             tick_reg;
  logic             at_max;

  // Terminal count reached; >= keeps the compare safe even if max_cur dropped.
  assign at_max = (count_reg >= max_cur_reg);

  // Single FSM/datapath register block; tick defaults low so it is a one-cycle pulse.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      tick_reg    <= 1'b0;
      mode_q      <= 1'b0;
      pending_reg <= 1'b0;
      shadow_reg  <= RST_MAX;
      max_cur_reg <= RST_MAX;
    end else begin
      tick_reg <= 1'b0;
      if (bus.clear) begin
        // Abort wins over everything; a staged value is not lost on abort.
        state_reg   <= IDLE;
        count_reg   <= '0;
        mode_q      <= 1'b0;
        pending_reg <= 1'b0;
        if (bus.load) begin
          max_cur_reg <= bus.max_in;
        end else if (pending_reg) begin
          max_cur_reg <= shadow_reg;
        end
      end else begin
        case (state_reg)
          IDLE, DONE: begin
            if (bus.load) begin
              max_cur_reg <= bus.max_in;
            end
            if (bus.start) begin
              state_reg <= RUN;
              count_reg <= '0;
              mode_q    <= bus.mode;
            end
          end
          RUN: begin
            if (bus.enable && at_max) begin
              // Wrap: emit tick, commit the newest terminal value, maybe finish.
              count_reg   <= '0;
              tick_reg    <= 1'b1;
              pending_reg <= 1'b0;
              if (bus.load) begin
                max_cur_reg <= bus.max_in;
                shadow_reg  <= bus.max_in;
              end else if (pending_reg) begin
                max_cur_reg <= shadow_reg;
              end
              if (mode_q) begin
                state_reg <= DONE;
              end
            end else begin
              if (bus.load) begin
                shadow_reg  <= bus.max_in;
                pending_reg <= 1'b1;
              end
              if (bus.enable) begin
                count_reg <= count_reg + ONE;
              end
            end
          end
          default: begin
            state_reg <= IDLE;
            count_reg <= '0;
          end
        endcase
      end
    end
  end

  assign bus.tick    = tick_reg;
  assign bus.busy    = (state_reg == RUN);
  assign bus.done    = (state_reg == DONE);
  assign bus.count   = count_reg;
  assign bus.max_cur = max_cur_reg;

endmodule

// File: tb/tb_prog_tick_divider.sv
// Scoreboard bench for prog_tick_divider: a driver applies directed and random
// stimulus, a reference model predicts the outputs after each edge, and a
// separate monitor compares the DUT against the queued predictions.
module tb_prog_tick_divider;

  localparam int W = 16;
  localparam logic [W-1:0] RMAX = 16'd9;

  typedef struct packed {
    logic         tick;
    logic         busy;
    logic         done;
    logic [W-1:0] count;
    logic [W-1:0] max_cur;
  } exp_t;

  logic clk;
  logic nRst;
  int   checks;
  int   errors;
  int   cyc_no;
  exp_t exp_q[$];

  prog_tick_divider_if #(.WIDTH(W)) bus ();

  prog_tick_divider #(.WIDTH(W), .RST_MAX(RMAX)) dut (
    .clk  (clk),
    .nRst (nRst),
    .bus  (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: run/finished flags, one-shot flag, integer counter,
  // terminal value and an optional staged terminal value.
  bit m_run, m_fin, m_os, m_pend, m_tick;
  int m_cnt, m_max, m_sh;

  task automatic model_reset();
    m_run = 0; m_fin = 0; m_os = 0; m_pend = 0; m_tick = 0;
    m_cnt = 0; m_max = int'(RMAX); m_sh = int'(RMAX);
  endtask

  task automatic model_step(input bit en, input bit clr, input bit st,
                            input bit md, input bit ld, input int mx);
    m_tick = 0;
    if (clr) begin
      if (ld) m_max = mx;
      else if (m_pend) m_max = m_sh;
      m_pend = 0; m_run = 0; m_fin = 0; m_cnt = 0; m_os = 0;
    end else if (!m_run) begin
      if (ld) m_max = mx;
      if (st) begin
        m_run = 1; m_fin = 0; m_cnt = 0; m_os = md;
      end
    end else if (en && m_cnt == m_max) begin
      m_tick = 1;
      m_cnt  = 0;
      if (ld) m_max = mx;
      else if (m_pend) m_max = m_sh;
      m_pend = 0;
      if (m_os) begin
        m_run = 0; m_fin = 1;
      end
    end else begin
      if (ld) begin
        m_sh = mx; m_pend = 1;
      end
      if (en) m_cnt = m_cnt + 1;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.tick    = m_tick;
    e.busy    = m_run;
    e.done    = m_fin;
    e.count   = W'(m_cnt);
    e.max_cur = W'(m_max);
    return e;
  endfunction

  // One transaction: drive inputs after the falling edge, predict the next edge.
  task automatic cyc(input bit rst_n, input bit en, input bit clr, input bit st,
                     input bit md, input bit ld, input int mx);
    exp_t e;
    @(negedge clk);
    nRst       = rst_n;
    bus.enable = en;
    bus.clear  = clr;
    bus.start  = st;
    bus.mode   = md;
    bus.load   = ld;
    bus.max_in = W'(mx);
    if (!rst_n) begin
      model_reset();
      #1;
      checks++;
      if (bus.count !== '0 || bus.tick !== 1'b0 || bus.busy !== 1'b0 ||
          bus.done !== 1'b0 || bus.max_cur !== RMAX) begin
        errors++;
        $display("FAIL async_reset: got count=%0d tick=%b busy=%b done=%b max_cur=%0d, want count=0 tick=0 busy=0 done=0 max_cur=%0d",
                 bus.count, bus.tick, bus.busy, bus.done, bus.max_cur, RMAX);
      end
    end else begin
      model_step(en, clr, st, md, ld, mx);
    end
    e = model_out();
    exp_q.push_back(e);
  endtask

  // Monitor: after every rising edge, pop one prediction and compare.
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{tick: bus.tick, busy: bus.busy, done: bus.done,
              count: bus.count, max_cur: bus.max_cur};
        cyc_no++;
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL cycle %0d: got tick=%b busy=%b done=%b count=%0d max_cur=%0d, want tick=%b busy=%b done=%b count=%0d max_cur=%0d",
                   cyc_no, a.tick, a.busy, a.done, a.count, a.max_cur,
                   e.tick, e.busy, e.done, e.count, e.max_cur);
        end else begin
          $display("cycle %0d: tick=%b busy=%b done=%b count=%0d max_cur=%0d",
                   cyc_no, a.tick, a.busy, a.done, a.count, a.max_cur);
        end
      end
    end
  end

  // Driver: directed scenarios, then randomized traffic.
  initial begin
    checks = 0; errors = 0; cyc_no = 0;
    nRst = 1'b0;
    bus.enable = 1'b0; bus.clear = 1'b0; bus.start = 1'b0;
    bus.mode = 1'b0; bus.load = 1'b0; bus.max_in = '0;
    model_reset();

    // Reset then release.
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);

    // Periodic divide-by-5.
    cyc(1, 0, 0, 0, 0, 1, 4);
    cyc(1, 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 15; i++) cyc(1, 1, 0, 0, 0, 0, 0);

    // One-shot with max 3, then rerun.
    cyc(1, 0, 1, 0, 0, 1, 3);
    cyc(1, 1, 0, 1, 1, 0, 0);
    for (int i = 0; i < 7; i++) cyc(1, 1, 0, (i == 2), 0, 0, 0);
    cyc(1, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 6; i++) cyc(1, 1, 0, 0, 0, 0, 0);

    // Shadowed load while running.
    cyc(1, 0, 1, 0, 0, 1, 7);
    cyc(1, 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 1, 2);
    for (int i = 0; i < 12; i++) cyc(1, 1, 0, 0, 0, 0, 0);

    // Enable low for 4 cycles at count 5.
    cyc(1, 0, 1, 0, 0, 1, 9);
    cyc(1, 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0, 0, 0);

    // Pending load, then clear and start together.
    cyc(1, 1, 0, 0, 0, 1, 5);
    cyc(1, 1, 1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);

    // Asynchronous reset mid-run at count 6.
    cyc(1, 0, 0, 0, 0, 1, 9);
    cyc(1, 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);

    // Terminal value 0: tick every enabled cycle.
    cyc(1, 0, 0, 0, 0, 1, 0);
    cyc(1, 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) != 0),
          ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 31) == 0),
          ($urandom_range(0, 7) == 0),
          1'($urandom_range(0, 1)),
          ($urandom_range(0, 7) == 0),
          int'($urandom_range(0, 12)));
    end

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked predictions, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_tick_divider.md
PROG_TICK_DIVIDER -- requirements
Module: prog_tick_divider

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, the counter and terminal-value width (WIDTH >= 2).
REQ-002 The module SHALL have parameter RST_MAX, default 16'd9, the active terminal value loaded at reset.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 nRst  input  1  reset, asynchronous, active-low.
REQ-005 enable  input  1  count-advance qualifier; low freezes count and state.
REQ-006 clear  input  1  synchronous abort to IDLE; highest priority.
REQ-007 start  input  1  launch counting from IDLE or DONE.
REQ-008 mode  input  1  0 = periodic, 1 = one-shot; sampled only when start is accepted.
REQ-009 load  input  1  write strobe for max_in.
REQ-010 max_in  input  WIDTH  new terminal value.
REQ-011 tick  output  1  registered one-cycle pulse per terminal count.
REQ-012 busy  output  1  high while in RUN.
REQ-013 done  output  1  high while in DONE.
REQ-014 count  output  WIDTH  current counter value.
REQ-015 max_cur  output  WIDTH  active terminal value.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and DONE; busy = (RUN), done = (DONE).
REQ-017 IDLE/DONE with start=1, clear=0: next state RUN, count=0, mode latched into mode_q; enable is not required.
REQ-018 RUN with start=1: start SHALL be ignored and mode_q SHALL stay unchanged.
REQ-019 RUN, enable=1, count != max_cur: count SHALL increment by 1.
REQ-020 RUN, enable=1, count == max_cur (wrap): count SHALL go to 0 and tick SHALL be 1 in the following cycle only.
REQ-021 On wrap with mode_q=0, state SHALL stay RUN; with mode_q=1, state SHALL go to DONE.
REQ-022 max_cur=0 in periodic mode: tick SHALL be high every cycle after the first enabled cycle while enable=1.
REQ-023 enable=0: count, state and the pending load SHALL hold; tick SHALL be 0 the next cycle.
REQ-024 count SHALL never exceed max_cur, including after a load lowers max_cur.
REQ-025 load in IDLE/DONE: max_cur SHALL take max_in at the next edge.
REQ-026 load in RUN: max_in SHALL go to a shadow register with pending=1; max_cur SHALL update at the next wrap edge, then pending clears.
REQ-027 A load coincident with a wrap SHALL take effect at that same wrap edge.
REQ-028 A later load while pending SHALL overwrite the shadow value (last write wins).
REQ-029 clear=1: next state IDLE, count=0, tick=0, mode_q=0.
REQ-030 On clear, any pending shadow value SHALL be committed to max_cur.
REQ-031 clear with start in the same cycle: clear SHALL win and start is dropped.
REQ-032 clear with load in the same cycle: max_cur SHALL take max_in.
REQ-033 DONE SHALL hold count=0 until start or clear.

Reset
REQ-034 nRst low SHALL asynchronously force state=IDLE, count=0, tick=0, mode_q=0, pending=0, shadow=RST_MAX, max_cur=RST_MAX.
REQ-035 nRst asserted mid-RUN SHALL abort the run with no tick emitted afterwards.
REQ-036 Release of nRst SHALL take effect on the next rising clk, with no outputs other than the reset values before it.

Verification
REQ-037 Reset, load max_in=4 in IDLE, start mode=0, enable=1 for 15 cycles -> tick every 5th cycle, count sequence 0..4 repeating, busy=1.
REQ-038 Start mode=1 with max_cur=3, enable=1 -> exactly one tick, then done=1, busy=0, count=0; a second start reruns the sequence.
REQ-039 Periodic run with max_cur=7, load max_in=2 at count=3 -> count continues to 7, wraps, then the period is 3 cycles; max_cur changes only at the wrap.
REQ-040 Toggle enable low for 4 cycles at count=5 -> count holds 5, no tick, resumes at 6.
REQ-041 clear and start in the same cycle during RUN -> IDLE, count=0, busy=0, no tick; pending load committed to max_cur.
REQ-042 nRst pulse mid-RUN at count=6 -> immediate count=0, IDLE, max_cur=RST_MAX, no tick.
